// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start/serve/score/win FSM with serve-delay counter and LFSR serve angle.
// Command pulses (ball_center, serve) are combinational in the cycle whose inputs trigger them.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_center,
  output logic       serve,
  output logic       serve_dir,
  output logic [2:0] angle_sel,
  output logic       ball_enable,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_SCORED     = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       start_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] angle_q, angle_d;
  logic       dir_q, dir_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic [1:0] winner_q, winner_d;

  logic       press;
  logic       delay_done;
  logic       miss_l_only;
  logic       miss_r_only;
  logic       any_miss;
  logic       win_l;
  logic       win_r;
  logic [2:0] lfsr_angle;

  assign press       = start & ~start_q;
  assign delay_done  = frame_tick & (({1'b0, cnt_q} + 9'd1) == 9'(SERVE_DELAY));
  assign miss_l_only = frame_tick & miss_left & ~miss_right;
  assign miss_r_only = frame_tick & miss_right & ~miss_left;
  assign any_miss    = frame_tick & (miss_left | miss_right);
  assign win_l       = (score_l_q == 4'(WIN_SCORE));
  assign win_r       = (score_r_q == 4'(WIN_SCORE));
  // Angle 0 would be a flat serve; it is remapped to the shallowest real angle.
  assign lfsr_angle  = (lfsr_q[2:0] == 3'd0) ? 3'b001 : lfsr_q[2:0];

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      cnt_q     <= 8'd0;
      lfsr_q    <= 8'h01;
      angle_q   <= 3'b001;
      dir_q     <= 1'b1;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      winner_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      angle_q   <= angle_d;
      dir_q     <= dir_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: if (press) state_d = S_SERVE_WAIT;
      S_SERVE_WAIT:        if (delay_done) state_d = S_PLAY;
      S_PLAY:              if (any_miss) state_d = S_SCORED;
      S_SCORED:            state_d = (win_l || win_r) ? S_GAME_OVER : S_SERVE_WAIT;
      default:             state_d = S_IDLE;
    endcase
  end

  // FSM outputs; pulses are suppressed while reset is asserted.
  always_comb begin
    ball_center = 1'b0;
    serve       = 1'b0;
    ball_enable = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: ball_center = reset & press;
      S_SERVE_WAIT:        serve       = reset & delay_done;
      S_PLAY:              ball_enable = 1'b1;
      S_SCORED:            ball_center = reset;
      default:             ball_center = 1'b0;
    endcase
  end

  // Datapath next values: delay counter, LFSR, serve parameters, scores, winner.
  always_comb begin
    cnt_d     = 8'd0;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    angle_d   = angle_q;
    dir_d     = dir_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (press) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
          dir_d     = 1'b1;
        end
      end
      S_SERVE_WAIT: begin
        cnt_d = frame_tick ? cnt_q + 8'd1 : cnt_q;
        if (delay_done) angle_d = lfsr_angle;
      end
      S_PLAY: begin
        if (miss_l_only) begin
          score_r_d = (score_r_q == 4'hF) ? 4'hF : score_r_q + 4'd1;
          dir_d     = 1'b0;
        end else if (miss_r_only) begin
          score_l_d = (score_l_q == 4'hF) ? 4'hF : score_l_q + 4'd1;
          dir_d     = 1'b1;
        end
      end
      S_SCORED: begin
        if (win_l)      winner_d = 2'b01;
        else if (win_r) winner_d = 2'b10;
      end
      default: cnt_d = 8'd0;
    endcase
  end

  assign serve_dir = dir_q;
  assign angle_sel = serve ? lfsr_angle : angle_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl (SERVE_DELAY=3, WIN_SCORE=2): vector table, corner sequences,
// and random play checked every cycle against a game-rule reference model.
module tb_pong_game_ctrl;

  localparam int SD = 3;
  localparam int WS = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, tick, ml, mr;
  logic       ball_center, serve, serve_dir, ball_enable;
  logic [2:0] angle_sel, state;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;

  int n_tests = 0;
  int n_fail  = 0;

  pong_game_ctrl #(.WIN_SCORE(WS), .SERVE_DELAY(SD)) dut (
    .clk(clk), .reset(rst_n), .frame_tick(tick), .start(start),
    .miss_left(ml), .miss_right(mr), .ball_center(ball_center), .serve(serve),
    .serve_dir(serve_dir), .angle_sel(angle_sel), .ball_enable(ball_enable),
    .score_l(score_l), .score_r(score_r), .winner(winner), .state(state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (game rules) ----------------
  // Phase numbers are the externally visible state codes.
  int         m_phase, m_sl, m_sr, m_ticks;
  logic [1:0] m_win;
  logic       m_dir, m_prev_start, m_valid = 1'b0;
  logic [2:0] m_angle;
  logic [7:0] m_lfsr;

  // x^8+x^6+x^5+x^4+1 as a left-shifting register fed from bits 7,5,4,3.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [2:0] pick_angle(input logic [7:0] v);
    return (v[2:0] == 3'd0) ? 3'b001 : v[2:0];
  endfunction

  function automatic int sat_inc(input int s);
    return (s >= 15) ? 15 : s + 1;
  endfunction

  logic       e_press, e_bc, e_sv;
  logic [2:0] e_ang;
  logic [19:0] act_v, exp_v;

  always @(negedge clk) begin
    e_press = start && !m_prev_start;
    if (m_valid) begin
      e_bc  = rst_n && ((((m_phase == 0) || (m_phase == 4)) && e_press) || (m_phase == 3));
      e_sv  = rst_n && (m_phase == 1) && tick && (m_ticks + 1 == SD);
      e_ang = e_sv ? pick_angle(m_lfsr) : m_angle;
      exp_v = {3'(m_phase), e_bc, e_sv, m_dir, e_ang, (m_phase == 2), 4'(m_sl), 4'(m_sr), m_win};
      act_v = {state, ball_center, serve, serve_dir, angle_sel, ball_enable, score_l, score_r, winner};
      check("model", 32'(act_v), 32'(exp_v));
    end
    if (!rst_n) begin
      m_phase = 0; m_sl = 0; m_sr = 0; m_ticks = 0; m_win = 2'b00;
      m_dir = 1'b1; m_angle = 3'b001; m_lfsr = 8'h01; m_prev_start = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0, 4: if (e_press) begin
          m_phase = 1; m_sl = 0; m_sr = 0; m_win = 2'b00; m_dir = 1'b1; m_ticks = 0;
        end
        1: if (tick) begin
          if (m_ticks + 1 == SD) begin m_phase = 2; m_angle = pick_angle(m_lfsr); end
          else m_ticks++;
        end
        2: if (tick && (ml || mr)) begin
          if (ml && !mr)      begin m_sr = sat_inc(m_sr); m_dir = 1'b0; end
          else if (mr && !ml) begin m_sl = sat_inc(m_sl); m_dir = 1'b1; end
          m_phase = 3;
        end
        3: begin
          if (m_sl == WS)      begin m_win = 2'b01; m_phase = 4; end
          else if (m_sr == WS) begin m_win = 2'b10; m_phase = 4; end
          else                 begin m_phase = 1; m_ticks = 0; end
        end
        default: m_phase = 0;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
      m_prev_start = start;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic r, input logic s, input logic t, input logic l, input logic g);
    rst_n = r; start = s; tick = t; ml = l; mr = g;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    repeat (2) next_cycle();
    drive(1, 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, st, tk, l, r;
    logic [2:0] e_state;
    logic       e_bc, e_sv, e_be;
    logic [3:0] e_sl, e_sr;
    logic [1:0] e_win;
    logic       e_dir;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, st, tk, l, r, input logic [2:0] s,
                              input logic bc, sv, be, input logic [3:0] sl, sr,
                              input logic [1:0] w, input logic d);
    vec_t v;
    v.rst = rst; v.st = st; v.tk = tk; v.l = l; v.r = r; v.e_state = s;
    v.e_bc = bc; v.e_sv = sv; v.e_be = be; v.e_sl = sl; v.e_sr = sr; v.e_win = w; v.e_dir = d;
    tbl.push_back(v);
  endfunction

  initial begin
    int bc_n, trans_n, waited;
    logic [2:0] prev_state;
    drive(0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    //  rst st tk ml mr | state bc sv be  sl sr win dir
    add(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 1);  // held in reset
    add(1, 1, 0, 0, 0,   0, 1, 0, 0,  0, 0, 0, 1);  // start press
    add(1, 1, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);  // start held
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 1, 0,  0, 0, 0, 1);  // third tick: serve
    add(1, 0, 0, 0, 0,   2, 0, 0, 1,  0, 0, 0, 1);
    add(1, 0, 1, 0, 1,   2, 0, 0, 1,  0, 0, 0, 1);  // miss_right
    add(1, 0, 0, 0, 0,   3, 1, 0, 0,  1, 0, 0, 1);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  1, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  1, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 1, 0,  1, 0, 0, 1);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1,  1, 0, 0, 1);
    add(1, 0, 1, 0, 0,   2, 0, 0, 1,  1, 0, 0, 1);  // tick, no miss
    add(1, 0, 0, 0, 1,   2, 0, 0, 1,  1, 0, 0, 1);  // miss without tick
    add(1, 0, 1, 1, 0,   2, 0, 0, 1,  1, 0, 0, 1);  // miss_left
    add(1, 0, 0, 0, 0,   3, 1, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 1, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1,  1, 1, 0, 0);
    add(1, 0, 1, 1, 1,   2, 0, 0, 1,  1, 1, 0, 0);  // double miss: replay
    add(1, 0, 0, 0, 0,   3, 1, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  1, 1, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 1, 0,  1, 1, 0, 0);
    add(1, 0, 0, 0, 0,   2, 0, 0, 1,  1, 1, 0, 0);
    add(1, 0, 1, 0, 1,   2, 0, 0, 1,  1, 1, 0, 0);  // winning point
    add(1, 0, 0, 0, 0,   3, 1, 0, 0,  2, 1, 0, 1);
    add(1, 0, 0, 0, 0,   4, 0, 0, 0,  2, 1, 1, 1);
    add(1, 0, 1, 1, 0,   4, 0, 0, 0,  2, 1, 1, 1);  // miss in GAME_OVER
    add(1, 0, 0, 0, 0,   4, 0, 0, 0,  2, 1, 1, 1);
    add(1, 1, 0, 0, 0,   4, 1, 0, 0,  2, 1, 1, 1);  // restart press
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);
    add(0, 0, 1, 0, 0,   1, 0, 0, 0,  0, 0, 0, 1);  // reset on the serving tick
    add(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].tk, tbl[i].l, tbl[i].r);
      @(negedge clk);
      check($sformatf("vec[%0d]", i),
            32'({state, ball_center, serve, ball_enable, score_l, score_r, winner, serve_dir}),
            32'({tbl[i].e_state, tbl[i].e_bc, tbl[i].e_sv, tbl[i].e_be,
                 tbl[i].e_sl, tbl[i].e_sr, tbl[i].e_win, tbl[i].e_dir}));
      if (tbl[i].e_sv) check($sformatf("vec[%0d]_angle_nz", i), 32'(angle_sel != 3'd0), 32'd1);
      next_cycle();
    end

    // Start held for 100 cycles: a single press.
    do_reset();
    @(negedge clk);
    prev_state = state;
    next_cycle();
    bc_n = 0; trans_n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1, 1, 0, 0, 0);
      @(negedge clk);
      if (ball_center) bc_n++;
      if (state != prev_state) trans_n++;
      prev_state = state;
      next_cycle();
    end
    check("held_start_ball_center", 32'(bc_n), 32'd1);
    check("held_start_transitions", 32'(trans_n), 32'd1);
    check("held_start_state", 32'(state), 32'd1);

    // Serve timed so the LFSR low bits are zero, then reset mid-PLAY.
    drive(1, 0, 0, 0, 0);
    do_reset();
    drive(1, 1, 0, 0, 0); next_cycle();
    drive(1, 0, 1, 0, 0); next_cycle();
    drive(1, 0, 1, 0, 0); next_cycle();
    drive(1, 0, 0, 0, 0);
    waited = 0;
    while (m_lfsr[2:0] != 3'd0 && waited < 600) begin
      next_cycle();
      waited++;
    end
    check("lfsr_zero_reached", 32'(m_lfsr[2:0] == 3'd0), 32'd1);
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check("zero_angle_serve", 32'(serve), 32'd1);
    check("zero_angle_sel", 32'(angle_sel), 32'd1);
    next_cycle();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("zero_angle_play", 32'(state), 32'd2);
    next_cycle();
    drive(0, 0, 1, 0, 1);
    @(negedge clk);
    check("reset_cycle_no_serve", 32'(serve), 32'd0);
    next_cycle();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("after_reset_outputs",
          32'({state, ball_center, serve, serve_dir, angle_sel, ball_enable, score_l, score_r, winner}),
          32'({3'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 4'd0, 4'd0, 2'b00}));
    next_cycle();

    // Random play, checked by the model each cycle.
    for (int k = 0; k < 4000; k++) begin
      drive(($urandom_range(0, 399) != 0),
            ($urandom_range(0, 14) == 0) ? ~start : start,
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win a game (range 1..15).
REQ-002 Parameter SERVE_DELAY, default 60: frame_tick pulses to wait before each serve (range 1..255).
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-low.
REQ-005 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-006 Port start, input, 1: level from the start button, edge-detected internally.
REQ-007 Port miss_left, input, 1: ball passed the left paddle; valid only on frame_tick cycles.
REQ-008 Port miss_right, input, 1: ball passed the right paddle; valid only on frame_tick cycles.
REQ-009 Port ball_center, output, 1: one-cycle pulse commanding ball movement logic to place the ball at (31,31).
REQ-010 Port serve, output, 1: one-cycle pulse launching the ball.
REQ-011 Port serve_dir, output, 1: serve direction, 0 = left, 1 = right; valid whenever serve is high.
REQ-012 Port angle_sel, output, 3: serve angle index, never 0; valid whenever serve is high.
REQ-013 Port ball_enable, output, 1: ball may move; high only in PLAY.
REQ-014 Port score_l, output, 4: left player score.
REQ-015 Port score_r, output, 4: right player score.
REQ-016 Port winner, output, 2: 00 none, 01 left, 10 right.
REQ-017 Port state, output, 3: current FSM state encoding.

Function
REQ-018 FSM states, with fixed encodings: IDLE=0, SERVE_WAIT=1, PLAY=2, SCORED=3, GAME_OVER=4; other codes go to IDLE on the next cycle.
REQ-019 Start press = start high this cycle and low the previous cycle; a held start causes no further presses.
REQ-020 IDLE: start press -> SERVE_WAIT; same cycle, scores clear, winner=00, ball_center pulses, serve_dir=1.
REQ-021 SERVE_WAIT: 8-bit delay counter clears on entry and increments on each frame_tick.
REQ-022 SERVE_WAIT exit: on the frame_tick bringing the counter to SERVE_DELAY -> PLAY; same cycle, serve pulses and angle_sel latches from the LFSR.
REQ-023 LFSR: 8-bit, free-running every cycle, taps x^8+x^6+x^5+x^4+1.
REQ-024 angle_sel = lfsr[2:0], substituting 3'b001 when lfsr[2:0] = 0; held until the next serve.
REQ-025 PLAY: ball_enable=1; frame_tick with miss_left only -> score_r+1, serve_dir=0, go SCORED.
REQ-026 PLAY: frame_tick with miss_right only -> score_l+1, serve_dir=1, go SCORED.
REQ-027 PLAY: both misses on one frame_tick -> no score change, serve_dir unchanged, go SCORED (replay point).
REQ-028 Misses outside PLAY, or without frame_tick, are ignored.
REQ-029 SCORED lasts exactly one cycle and pulses ball_center.
REQ-030 SCORED exit: if either score equals WIN_SCORE -> GAME_OVER, winner set to that side; else -> SERVE_WAIT.
REQ-031 Scores saturate at 15 and never wrap.
REQ-032 GAME_OVER: scores and winner held, ball_enable=0; start press behaves as in IDLE (REQ-020).
REQ-033 ball_enable is 0 in all states except PLAY; serve and ball_center are never high in the same cycle.

Reset
REQ-034 reset low at a clock edge -> state=IDLE, scores=0, winner=00, serve_dir=1, angle_sel=3'b001, lfsr=8'h01, delay counter=0, all pulses 0, ball_enable=0.
REQ-035 Reset mid-PLAY or mid-SERVE_WAIT aborts immediately; no serve or score pulse is emitted in the reset cycle or the cycle after.

Verification
REQ-036 SERVE_DELAY=3: reset, start press, 3 frame_ticks -> ball_center at the press cycle; serve with serve_dir=1 and angle_sel≠0 on the third tick; state=2.
REQ-037 In PLAY, frame_tick with miss_left=1 -> score_r 0->1, serve_dir=0, SCORED for one cycle with ball_center, then SERVE_WAIT.
REQ-038 WIN_SCORE=2: two miss_right points -> score_l=2, winner=01, state=4; further misses leave scores unchanged.
REQ-039 Simultaneous miss_left and miss_right on one tick -> scores unchanged, SCORED then SERVE_WAIT, serve_dir unchanged.
REQ-040 start held high for 100 cycles from IDLE -> exactly one transition and one ball_center pulse.
REQ-041 Drive LFSR to lfsr[2:0]=0 at serve -> angle_sel=3'b001; reset asserted mid-PLAY -> all outputs at REQ-034 values next cycle.
